// File: rtl/rr_sel_arbiter4_if.sv
// Bus bundle for rr_sel_arbiter4: client request/enable/release inputs and the
// active-low one-hot select outputs.
interface rr_sel_arbiter4_if;
  logic       en_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt_n;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (
    output en_n, req, done,
    input  gnt_n, gnt_idx, gnt_valid
  );

  modport slave (
    input  en_n, req, done,
    output gnt_n, gnt_idx, gnt_valid
  );
endinterface

// File: rtl/rr_sel_arbiter4.sv
// Four-client round-robin arbiter with an active-low one-hot grant bus.
// Define ARB_TIMEOUT_EN to force-release any grant after HOLD_MAX cycles.
module rr_sel_arbiter4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_sel_arbiter4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] gntN_q, gntN_d;
  logic [1:0] gntIdx_q, gntIdx_d;
  logic       gntValid_q, gntValid_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       anyReq;
  logic       relNow;
  logic       timeout;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : gHoldCheck
    $error("HOLD_MAX must be within 1..255");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] holdCnt_q, holdCnt_d;

  assign timeout = (holdCnt_q == 8'(HOLD_MAX - 1));

  always_comb begin
    holdCnt_d = 8'd0;
    if (state_q == GRANT && state_d == GRANT) begin
      holdCnt_d = (holdCnt_q == 8'hFF) ? holdCnt_q : holdCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCnt_q <= 8'd0;
    end else begin
      holdCnt_q <= holdCnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Scan from the highest offset down so the nearest requester after ptr wins.
  always_comb begin
    winner = ptr_q;
    anyReq = 1'b0;
    cand   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (bus.req[cand]) begin
        winner = cand;
        anyReq = 1'b1;
      end
    end
  end

  assign relNow = bus.done | ~bus.req[gntIdx_q] | bus.en_n | timeout;

  always_comb begin
    state_d    = state_q;
    gntN_d     = gntN_q;
    gntIdx_d   = gntIdx_q;
    gntValid_d = gntValid_q;
    ptr_d      = ptr_q;
    case (state_q)
      IDLE: begin
        gntN_d     = 4'hF;
        gntValid_d = 1'b0;
        if (!bus.en_n && anyReq) begin
          state_d    = GRANT;
          gntN_d     = ~(4'b0001 << winner);
          gntIdx_d   = winner;
          gntValid_d = 1'b1;
        end
      end
      GRANT: begin
        if (relNow) begin
          state_d    = IDLE;
          gntN_d     = 4'hF;
          gntValid_d = 1'b0;
          ptr_d      = gntIdx_q + 2'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        gntN_d     = 4'hF;
        gntValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gntN_q     <= 4'hF;
      gntIdx_q   <= 2'd0;
      gntValid_q <= 1'b0;
      ptr_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      gntN_q     <= gntN_d;
      gntIdx_q   <= gntIdx_d;
      gntValid_q <= gntValid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.gnt_n     = gntN_q;
  assign bus.gnt_idx   = gntIdx_q;
  assign bus.gnt_valid = gntValid_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Self-checking bench for rr_sel_arbiter4: directed vectors plus a
// cycle-level round-robin model compared on every falling clock edge.
module tb_rr_sel_arbiter4;

  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   errCount   = 0;
  bit   chkEn      = 1'b0;

  rr_sel_arbiter4_if bus ();

  rr_sel_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: who holds the slot, for how long, and where the search starts.
  bit mValid = 1'b0;
  int mIdx   = 0;
  int mPtr   = 0;
  int mHeld  = 0;

  function automatic int pickWinner(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  function automatic bit timedOut(int held);
`ifdef ARB_TIMEOUT_EN
    return held >= HOLD;
`else
    return (held < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid <= 1'b0;
      mIdx   <= 0;
      mPtr   <= 0;
      mHeld  <= 0;
    end else if (!mValid) begin
      if (!bus.en_n && bus.req != 4'b0000) begin
        mValid <= 1'b1;
        mIdx   <= pickWinner(bus.req, mPtr);
        mHeld  <= 1;
      end
    end else begin
      if (bus.done || !bus.req[mIdx] || bus.en_n || timedOut(mHeld)) begin
        mValid <= 1'b0;
        mPtr   <= (mIdx + 1) % 4;
      end else begin
        mHeld <= mHeld + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] expN;
    logic [1:0] expIdx;
    if (chkEn) begin
      expIdx = 2'(mIdx);
      expN   = mValid ? ~(4'b0001 << expIdx) : 4'hF;
      checkCount++;
      if (bus.gnt_n !== expN || bus.gnt_valid !== mValid || bus.gnt_idx !== expIdx) begin
        errCount++;
        $display("[TB] FAIL model t=%0t: gnt_n=%b valid=%b idx=%0d, required gnt_n=%b valid=%b idx=%0d",
                 $time, bus.gnt_n, bus.gnt_valid, bus.gnt_idx, expN, mValid, expIdx);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic en, input logic [3:0] r, input logic d);
    bus.en_n = en;
    bus.req  = r;
    bus.done = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expN,
                             input logic expValid, input logic [1:0] expIdx);
    checkCount++;
    if (bus.gnt_n !== expN || bus.gnt_valid !== expValid || bus.gnt_idx !== expIdx) begin
      errCount++;
      $display("[TB] FAIL %s: gnt_n=%b valid=%b idx=%0d, required gnt_n=%b valid=%b idx=%0d",
               name, bus.gnt_n, bus.gnt_valid, bus.gnt_idx, expN, expValid, expIdx);
    end
  endtask

  logic [3:0] fairExp [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    rst_n    = 1'b0;
    bus.en_n = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chkEn = 1'b1;
    checkOutput("reset_state", 4'hF, 1'b0, 2'd0);
    rst_n = 1'b1;

    // Asynchronous reset while client 2 holds the slot.
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("pre_reset_grant", 4'b1011, 1'b1, 2'd2);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_reset", 4'hF, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput("fair_grant", fairExp[i], 1'b1, 2'(i % 4));
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("fair_bubble", 4'hF, 1'b0, 2'(i % 4));
    end

    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("single_grant", 4'b1011, 1'b1, 2'd2);
    applyStimulus(1'b0, 4'b0100, 1'b1);
    checkOutput("single_done", 4'hF, 1'b0, 2'd2);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("single_regrant", 4'b1011, 1'b1, 2'd2);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("single_drop", 4'hF, 1'b0, 2'd2);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0);
      checkOutput("disabled", 4'hF, 1'b0, 2'd2);
    end
    applyStimulus(1'b0, 4'b0010, 1'b0);
    checkOutput("en_grant1", 4'b1101, 1'b1, 2'd1);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("en_release", 4'hF, 1'b0, 2'd1);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    checkOutput("en_circular", 4'b1110, 1'b1, 2'd0);
    applyStimulus(1'b0, 4'b0011, 1'b1);
    checkOutput("en_done", 4'hF, 1'b0, 2'd0);

    applyStimulus(1'b0, 4'b1000, 1'b0);
    checkOutput("drop_grant3", 4'b0111, 1'b1, 2'd3);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("drop_release", 4'hF, 1'b0, 2'd3);
    applyStimulus(1'b0, 4'b1001, 1'b0);
    checkOutput("drop_wrap", 4'b1110, 1'b1, 2'd0);
    applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("drop_done", 4'hF, 1'b0, 2'd0);

    // Long hold of client 0: bounded by HOLD only when the timeout is built.
    for (int c = 1; c <= 22; c++) begin
      applyStimulus(1'b0, 4'b0001, 1'b0);
`ifdef ARB_TIMEOUT_EN
      if (((c - 1) % (HOLD + 1)) < HOLD)
        checkOutput("timeout_hold", 4'b1110, 1'b1, 2'd0);
      else
        checkOutput("timeout_gap", 4'hF, 1'b0, 2'd0);
`else
      checkOutput("no_timeout_hold", 4'b1110, 1'b1, 2'd0);
`endif
    end
    applyStimulus(1'b0, 4'b0001, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("final_idle", 4'hF, 1'b0, 2'd0);

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/rr_sel_arbiter4.md
Name: rr_sel_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one resource slot among four clients.
- Its grant output is an active-low one-hot select, encoded exactly like the team's 2:4 active-low decoder output, so it can drive the same enable lines directly.
- Enable is active-low, matching the decoder's enable polarity.
- Sits between client request lines and the shared-resource select bus.

Parameters:
- HOLD_MAX, 8, maximum cycles one grant may be held when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en_n  input  1  active-low arbiter enable; 1 forces no grant
- req  input  4  active-high request, one bit per client
- done  input  1  active-high release strobe from the granted client
- gnt_n  output  4  active-low one-hot grant: client 0=1110, 1=1101, 2=1011, 3=0111, none=1111
- gnt_idx  output  2  index of the granted client; holds its last value when no grant
- gnt_valid  output  1  high while a grant is active

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt_n=1111, gnt_idx=00, gnt_valid=0, priority pointer ptr=0, hold counter=0. Takes effect immediately, including mid-grant.
- All outputs are registered. The outputs are never X.
- FSM states: IDLE, GRANT. Any illegal encoding returns to IDLE on the next edge.
- IDLE:
  - If en_n=0 and req!=0000: grant the first set req bit searching circularly ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: state goes to GRANT, gnt_n takes the decoded value, gnt_idx=winner, gnt_valid=1, counter=0.
  - Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE with gnt_n=1111.
- GRANT: the grant holds unchanged while req[gnt_idx]=1, done=0, en_n=0, and no timeout. Any of these release conditions ends it at the next edge:
  - done=1
  - req[gnt_idx]=0
  - en_n=1
  - timeout
- On release: gnt_n=1111, gnt_valid=0, ptr=(gnt_idx+1) mod 4 (2-bit wrap, 3->0), state=IDLE. gnt_idx keeps its value.
- At least one idle cycle always separates consecutive grants. Back-to-back grants to different clients are therefore 1 bubble apart.
- Simultaneous release conditions are treated as a single release, with one pointer advance.
- The pointer advances on every release, whatever the cause.
- done is ignored in IDLE. Changes on req bits other than gnt_idx are ignored in GRANT.
- Hold counter: 8 bits. It increments each GRANT cycle and saturates at 255. It is used only for timeout.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A grant is force-released after exactly HOLD_MAX cycles of gnt_valid=1, i.e. release at the edge where counter==HOLD_MAX-1.
  - With HOLD_MAX=1, every grant lasts exactly one cycle.
- Not defined:
  - No counter logic is built.
  - A grant persists until done, req drop, or en_n=1, with no upper bound.

Test Plan:
- Reset mid-operation: grant active on client 2, drive rst_n=0 between edges -> gnt_n=1111 and gnt_valid=0 immediately (asynchronous). After release, req=1111 grants client 0 first (1110).
- Single request: en_n=0, req=0100 -> next edge gnt_n=1011, gnt_idx=10, gnt_valid=1. Then pulse done -> next edge gnt_n=1111. Re-raise req -> one idle cycle, then 1011 again.
- Fairness: req=1111 held, done pulsed 1 cycle after each grant -> grant sequence 1110, 1101, 1011, 0111, 1110, with one 1111 cycle between each.
- Enable:
  - en_n=1, req=1111 for 10 cycles -> gnt_n stays 1111.
  - During a grant to client 1, drive en_n=1 -> next edge 1111, ptr=2.
  - With en_n=0 and req=0011 -> grants client 0 (circular search 2, 3, 0).
- Request drop: grant to client 3, then req[3] goes 0 -> released next edge. With req=1001, the next grant is client 0 (pointer wrapped 3->0).
- Timeout, with ARB_TIMEOUT_EN defined, HOLD_MAX=4, req=0001 held, done=0 -> gnt_valid high exactly 4 cycles, 1 idle cycle, then regrant to client 0.
- No timeout, macro not defined, same stimulus -> gnt_n=1110 held for 20+ cycles.
